udp_fragment_dispatcher: RTL
============================

// Module: udp_fragment_dispatcher
// PURPOSE
// Multi-queue UDP receive front end for a virtual port. It selects a pending receive queue
// round-robin and classifies the IPv4 fragment it holds (first or continuation). It binds
// that fragment to a fragment reassembly slot: an empty slot for a first fragment, or the
// slot with a matching packet ID. It then streams the payload beats into that slot.
// Fragments with no usable slot are drained and counted. Stalled streams are aborted by timeout.
// PARAMETERS
// RECEIVE_QUE_SLOTS  4    number of receive queues feeding this block (>=2)
// FRAGMENT_SLOTS     4    number of downstream reassembly slots (>=2)
// DATA_WIDTH         8    payload beat width in bits
// TIMEOUT_LIMIT      255  idle cycles allowed between accepted beats in S_STREAM
// PORTS
// clock                    in   1            system clock
// reset                    in   1            asynchronous, active-high reset
// rx_request               in   [Q]          queue q holds a fragment; its header fields are valid
// rx_ipv4_identification   in   [Q][16]      IPv4 identification per queue
// rx_ipv4_flags            in   [Q][16]      [13]=MF, [12:0]=fragment offset
// rx_data                  in   [Q][DW]      payload beat per queue
// rx_data_valid            in   [Q]          payload beat valid
// rx_data_last             in   [Q]          final beat of this fragment
// rx_data_ready            out  [Q]          beat accepted (one-hot or zero)
// fragment_slot_empty      in   [F]          slot f is unallocated
// fragment_slot_packet_id  in   [F][16]      packet ID owned by slot f
// fragment_slot_ready      in   [F]          slot f can take a beat this cycle
// push_data                out  DW           registered payload beat to slots
// push_data_valid          out  [F]          one-hot slot strobe
// push_data_first          out  [F]          beat is the first beat of a first fragment (offset 0)
// push_data_last           out  [F]          last beat of the final fragment (MF=0)
// push_data_abort          out  [F]          one-cycle pulse: slot stream timed out
// packet_id                out  16           ID of the fragment being serviced
// drop_count               out  16           saturating count of drained fragments
// busy                     out  1            state != S_IDLE
// BEHAVIOUR
// - Reset: every output 0, state S_IDLE, round-robin pointer 0, drop_count 0.
// - S_IDLE: scan from pointer+1 (mod Q) for the lowest-distance rx_request. Latch q, the
//   ID, MF and offset, then go to S_LOOKUP (1 cycle). No request: stay idle.
// - S_LOOKUP: combinational priority search over all F slots in one cycle, lowest index wins.
//   offset==0: match on fragment_slot_empty. Offset!=0: match on ~empty & packet_id equal.
//   Match -> latch slot, go to S_STREAM. No match -> go to S_DRAIN.
// - S_STREAM: rx_data_ready[q] = fragment_slot_ready[slot], combinational from registered
//   state; all other ready bits are 0.
//   On transfer (valid&ready): next cycle push_data=beat and push_data_valid=1<<slot.
//   push_data_first is set on the first beat only when offset==0.
//   push_data_last is set with the last beat only when rx_data_last & MF==0.
//   rx_data_last transfer -> S_IDLE and pointer=q. Latency rx->push = 1 cycle, throughput 1 beat/cycle.
// - Timeout: the counter reloads on entry to S_STREAM and on every transfer. When it reaches
//   TIMEOUT_LIMIT: push_data_abort=1<<slot for 1 cycle, go to S_DRAIN (the remaining beats are discarded).
// - S_DRAIN: rx_data_ready[q]=1, no push strobes; on the rx_data_last transfer ->
//   S_IDLE, pointer=q. drop_count +1 (saturate at 16'hFFFF) on S_DRAIN entry.
// - rx_request deasserting mid-stream is ignored; only rx_data_last ends service.
// - Simultaneous last beat and timeout expiry: the last beat wins, no abort.
// - fragment_slot_ready low holds the beat (no loss); a stall counts toward the timeout.
// - A zero-beat fragment is not legal; the first beat must exist.
// - Reset asserted mid-stream: outputs clear immediately; partial slot state is the slot's concern.
// - Arithmetic: pointer and slot indices use $clog2 widths with explicit wrap at Q-1/F-1.
// TESTING
// - Q0 request, ID 0x1234, MF=1, offset 0, slots 0,1 full, slot 2 empty, 4 beats ->
//   valid=0100 x4, first on beat 1, no last.
// - Q1 continuation, ID 0x1234, offset 0x00B9, MF=0, slot 2 ID 0x1234, 3 beats ->
//   valid=0100 x3, last=0100 with beat 3.
// - Q2 continuation, ID 0xBEEF, no slot match -> ready=1 until last, no push, drop_count 0->1.
// - Q0 and Q3 requesting together, pointer=0 -> Q1..Q3 scanned first, Q3 served, then Q0.
// - Stream stalls (rx_data_valid=0) for 256 cycles -> abort=1<<slot 1 cycle, remaining beats drained.
// - fragment_slot_ready toggles 1010..., 6 beats -> exactly 6 push strobes, data in order;
//   reset pulse mid-beat -> all outputs 0 next edge.

Source files
------------

// File: rtl/udp_fragment_dispatcher_if.sv
// Receive-queue and reassembly-slot bus of the UDP fragment dispatcher.
// The master side feeds queue headers/beats and slot status; the slave side is the dispatcher.
interface udp_fragment_dispatcher_if #(
    parameter int RECEIVE_QUE_SLOTS = 4,
    parameter int FRAGMENT_SLOTS    = 4,
    parameter int DATA_WIDTH        = 8
);
    logic [RECEIVE_QUE_SLOTS-1:0]                 rx_request;
    logic [RECEIVE_QUE_SLOTS-1:0][15:0]           rx_ipv4_identification;
    logic [RECEIVE_QUE_SLOTS-1:0][15:0]           rx_ipv4_flags;
    logic [RECEIVE_QUE_SLOTS-1:0][DATA_WIDTH-1:0] rx_data;
    logic [RECEIVE_QUE_SLOTS-1:0]                 rx_data_valid;
    logic [RECEIVE_QUE_SLOTS-1:0]                 rx_data_last;
    logic [RECEIVE_QUE_SLOTS-1:0]                 rx_data_ready;

    logic [FRAGMENT_SLOTS-1:0]                    fragment_slot_empty;
    logic [FRAGMENT_SLOTS-1:0][15:0]              fragment_slot_packet_id;
    logic [FRAGMENT_SLOTS-1:0]                    fragment_slot_ready;

    logic [DATA_WIDTH-1:0]                        push_data;
    logic [FRAGMENT_SLOTS-1:0]                    push_data_valid;
    logic [FRAGMENT_SLOTS-1:0]                    push_data_first;
    logic [FRAGMENT_SLOTS-1:0]                    push_data_last;
    logic [FRAGMENT_SLOTS-1:0]                    push_data_abort;

    modport master (
        output rx_request, rx_ipv4_identification, rx_ipv4_flags,
               rx_data, rx_data_valid, rx_data_last,
               fragment_slot_empty, fragment_slot_packet_id, fragment_slot_ready,
        input  rx_data_ready, push_data, push_data_valid, push_data_first,
               push_data_last, push_data_abort
    );

    modport slave (
        input  rx_request, rx_ipv4_identification, rx_ipv4_flags,
               rx_data, rx_data_valid, rx_data_last,
               fragment_slot_empty, fragment_slot_packet_id, fragment_slot_ready,
        output rx_data_ready, push_data, push_data_valid, push_data_first,
               push_data_last, push_data_abort
    );
endinterface

// File: rtl/udp_fragment_dispatcher.sv
// Round-robin receive-queue front end binding IPv4 fragments to reassembly slots.
//   state    | meaning
//   S_IDLE   | scan queues round-robin from pointer+1, latch header of the winner
//   S_LOOKUP | pick a free slot (offset 0) or the slot owning the packet ID
//   S_STREAM | forward beats into the bound slot, watch the idle timer
//   S_DRAIN  | swallow beats of an unplaceable or timed-out fragment
module udp_fragment_dispatcher #(
    parameter int RECEIVE_QUE_SLOTS = 4,
    parameter int FRAGMENT_SLOTS    = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int TIMEOUT_LIMIT     = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    udp_fragment_dispatcher_if.slave bus,
    output logic [15:0]              packet_id,
    output logic [15:0]              drop_count,
    output logic                     busy
);
    localparam int QW = (RECEIVE_QUE_SLOTS > 1) ? $clog2(RECEIVE_QUE_SLOTS) : 1;
    localparam int FW = (FRAGMENT_SLOTS > 1) ? $clog2(FRAGMENT_SLOTS) : 1;
    localparam int TW = $clog2(TIMEOUT_LIMIT + 1);
    localparam logic [QW-1:0] Q_LAST   = QW'(RECEIVE_QUE_SLOTS - 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(TIMEOUT_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_STREAM, S_DRAIN} state_t;

    state_t                    state, state_next;
    logic [QW-1:0]             rr_ptr, cur_q, scan_q, scan_idx;
    logic                      scan_hit;
    logic [FW-1:0]             cur_slot, lookup_slot;
    logic                      lookup_hit;
    logic                      cur_mf;
    logic [12:0]               cur_offset;
    logic                      first_pending;
    logic [TW-1:0]             timer;
    logic                      beat_valid, beat_last, cur_slot_ready;
    logic                      xfer, timed_out;
    logic [FRAGMENT_SLOTS-1:0] slot_onehot;

    assign beat_valid     = bus.rx_data_valid[cur_q];
    assign beat_last      = bus.rx_data_last[cur_q];
    assign cur_slot_ready = bus.fragment_slot_ready[cur_slot];
    assign slot_onehot    = FRAGMENT_SLOTS'(1) << cur_slot;
    assign busy           = (state != S_IDLE);

    // Queue nearest after the pointer wins; the pointer itself is visited last.
    always_comb begin
        scan_hit = 1'b0;
        scan_q   = '0;
        scan_idx = rr_ptr;
        for (int d = 0; d < RECEIVE_QUE_SLOTS; d++) begin
            scan_idx = (scan_idx == Q_LAST) ? '0 : scan_idx + 1'b1;
            if (!scan_hit && bus.rx_request[scan_idx]) begin
                scan_hit = 1'b1;
                scan_q   = scan_idx;
            end
        end
    end

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_slot = '0;
        for (int f = 0; f < FRAGMENT_SLOTS; f++) begin
            if (!lookup_hit) begin
                if (cur_offset == 13'd0 ? bus.fragment_slot_empty[f]
                    : (!bus.fragment_slot_empty[f] &&
                       bus.fragment_slot_packet_id[f] == packet_id)) begin
                    lookup_hit  = 1'b1;
                    lookup_slot = FW'(f);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // A transfer on the cycle the timer expires wins over the abort.
    always_comb begin
        state_next        = state;
        bus.rx_data_ready = '0;
        xfer              = 1'b0;
        timed_out         = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan_hit) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                state_next = lookup_hit ? S_STREAM : S_DRAIN;
            end
            S_STREAM: begin
                bus.rx_data_ready[cur_q] = cur_slot_ready;
                xfer = beat_valid && cur_slot_ready;
                if (xfer && beat_last) begin
                    state_next = S_IDLE;
                end else if (!xfer && timer == '0) begin
                    timed_out  = 1'b1;
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.rx_data_ready[cur_q] = 1'b1;
                xfer = beat_valid;
                if (xfer && beat_last) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr              <= '0;
            cur_q               <= '0;
            cur_slot            <= '0;
            cur_mf              <= 1'b0;
            cur_offset          <= '0;
            packet_id           <= '0;
            first_pending       <= 1'b0;
            timer               <= '0;
            drop_count          <= '0;
            bus.push_data       <= '0;
            bus.push_data_valid <= '0;
            bus.push_data_first <= '0;
            bus.push_data_last  <= '0;
            bus.push_data_abort <= '0;
        end else begin
            bus.push_data_valid <= '0;
            bus.push_data_first <= '0;
            bus.push_data_last  <= '0;
            bus.push_data_abort <= '0;
            case (state)
                S_IDLE: begin
                    if (scan_hit) begin
                        cur_q      <= scan_q;
                        packet_id  <= bus.rx_ipv4_identification[scan_q];
                        cur_mf     <= bus.rx_ipv4_flags[scan_q][13];
                        cur_offset <= bus.rx_ipv4_flags[scan_q][12:0];
                    end
                end
                S_LOOKUP: begin
                    cur_slot      <= lookup_slot;
                    first_pending <= 1'b1;
                    timer         <= T_RELOAD;
                    if (!lookup_hit && drop_count != 16'hFFFF)
                        drop_count <= drop_count + 1'b1;
                end
                S_STREAM: begin
                    if (xfer) begin
                        timer               <= T_RELOAD;
                        first_pending       <= 1'b0;
                        bus.push_data       <= bus.rx_data[cur_q];
                        bus.push_data_valid <= slot_onehot;
                        bus.push_data_first <= (first_pending && cur_offset == 13'd0)
                                               ? slot_onehot : '0;
                        bus.push_data_last  <= (beat_last && !cur_mf) ? slot_onehot : '0;
                    end else if (timed_out) begin
                        bus.push_data_abort <= slot_onehot;
                        if (drop_count != 16'hFFFF)
                            drop_count <= drop_count + 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: ;
            endcase
            if (xfer && beat_last) rr_ptr <= cur_q;
        end
    end
endmodule
